// File: rtl/mem_c_drain.sv
// Banked output buffer: the compute array writes whole rows, and a drain engine streams
// a contiguous run of rows lane-by-lane onto an AXI4-Stream master.
module mem_c_drain #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int BANKS  = 16,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH*BANKS-1:0]     wr_data,
    input  logic                       start,
    input  logic [$clog2(DEPTH)-1:0]   start_addr,
    input  logic [$clog2(DEPTH):0]     num_rows,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int LANE_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int ROW_W  = WIDTH * BANKS;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    (* ram_style = "ultra" *) logic [ROW_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]    rd_left_q, rd_left_d;
    logic [CNT_W-1:0]    out_left_q, out_left_d;
    logic [1:0]          inflight_q, inflight_d;
    logic [1:0]          bvalid_q, bvalid_d;
    logic                wptr_q, wptr_d;
    logic                rptr_q, rptr_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                done_q, done_d;
    logic [RD_LAT-1:0]   vld_q;

    logic [ADDR_W-1:0]   raddr_q;
    logic [ROW_W-1:0]    rdata_q [RD_LAT-1];
    logic [ROW_W-1:0]    rowbuf_q [2];

    logic                issue;
    logic                buf_wr;
    logic                hs;
    logic                last_lane;
    logic [2:0]          used;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Address register, then RD_LAT-1 data stages; vld_q tracks which stages hold real reads.
    always_ff @(posedge clk) begin
        raddr_q    <= rd_addr_q;
        rdata_q[0] <= mem[raddr_q];
        for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
            rdata_q[i] <= rdata_q[i-1];
        end
        if (buf_wr) begin
            rowbuf_q[wptr_q] <= rdata_q[RD_LAT-2];
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        inflight_d = inflight_q;
        bvalid_d   = bvalid_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        lane_d     = lane_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        buf_wr     = vld_q[RD_LAT-1];

        m_axis_tvalid = bvalid_q[rptr_q];
        last_lane     = (lane_q == LANE_W'(BANKS - 1));
        m_axis_tlast  = m_axis_tvalid && last_lane && (out_left_q == CNT_W'(1));
        m_axis_tdata  = m_axis_tvalid ? rowbuf_q[rptr_q][int'(lane_q)*WIDTH +: WIDTH] : '0;
        hs            = m_axis_tvalid && m_axis_tready;
        // Reads only go out while a buffer entry is guaranteed free when they land.
        used          = 3'(bvalid_q[0]) + 3'(bvalid_q[1]) + 3'(inflight_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        state_d    = RUN;
                        rd_addr_d  = start_addr;
                        rd_left_d  = num_rows;
                        out_left_d = num_rows;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                issue = (used < 3'd2);
                if (issue) begin
                    rd_addr_d = (rd_addr_q == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
                    rd_left_d = rd_left_q - CNT_W'(1);
                    if (rd_left_q == CNT_W'(1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (hs && m_axis_tlast) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (buf_wr) begin
            bvalid_d[wptr_q] = 1'b1;
            wptr_d           = ~wptr_q;
        end
        if (hs) begin
            if (last_lane) begin
                bvalid_d[rptr_q] = 1'b0;
                rptr_d           = ~rptr_q;
                lane_d           = '0;
                out_left_d       = out_left_d - CNT_W'(1);
            end else begin
                lane_d = lane_q + LANE_W'(1);
            end
        end

        case ({issue, buf_wr})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            rd_left_q  <= '0;
            out_left_q <= '0;
            inflight_q <= '0;
            bvalid_q   <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            lane_q     <= '0;
            done_q     <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            inflight_q <= inflight_d;
            bvalid_q   <= bvalid_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lane_q     <= lane_d;
            done_q     <= done_d;
            vld_q      <= {vld_q[RD_LAT-2:0], issue};
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mem_c_drain.sv
// Randomized scoreboard bench for mem_c_drain: a row-array model predicts every beat,
// and a negedge monitor pops and compares on each handshake.
module tb_mem_c_drain;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 512;
    localparam int BANKS  = 16;
    localparam int RD_LAT = 2;
    localparam int AW     = $clog2(DEPTH);
    localparam int ROW_W  = WIDTH * BANKS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [ROW_W-1:0]  wr_data;
    logic              start;
    logic [AW-1:0]     start_addr;
    logic [AW:0]       num_rows;
    logic              busy, done;
    logic [WIDTH-1:0]  m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;

    mem_c_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BANKS(BANKS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_addr(start_addr), .num_rows(num_rows),
        .busy(busy), .done(done), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_mode = 1;  // 0: low, 1: high, 2: random

    logic [ROW_W-1:0] model [DEPTH];
    logic [WIDTH:0]   exp_q [$];

    int beats = 0, first_v = -1, last_hs = -1, done_cyc = -1;
    int done_cnt = 0, busy_seen = 0, vld_seen = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, expv, cyc);
        end
    endfunction

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom % 2) == 1;
            endcase
        end
    end

    initial begin : monitor
        logic             prev_stall;
        logic [WIDTH-1:0] prev_data;
        logic             prev_last;
        logic [WIDTH:0]   e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_tvalid", m_axis_tvalid, 1);
                    chk("hold_tdata", m_axis_tdata, prev_data);
                    chk("hold_tlast", m_axis_tlast, prev_last);
                end
                if (m_axis_tvalid) begin
                    vld_seen++;
                    if (first_v < 0) first_v = cyc;
                end
                if (busy) busy_seen++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_beat: got tdata %0h with no beat expected", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", m_axis_tdata, e[WIDTH-1:0]);
                        chk("tlast", m_axis_tlast, e[WIDTH]);
                    end
                    beats++;
                    last_hs = cyc;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic write_row(input int a, input logic [ROW_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic push_expected(input int sa, input int n);
        int row;
        logic [ROW_W-1:0] r;
        for (int k = 0; k < n; k++) begin
            row = (sa + k) % DEPTH;
            r   = model[row];
            for (int l = 0; l < BANKS; l++) begin
                exp_q.push_back({(k == n - 1 && l == BANKS - 1), r[l*WIDTH +: WIDTH]});
            end
        end
    endtask

    task automatic issue_start(input int sa, input int n, output int cs);
        start      = 1'b1;
        start_addr = AW'(sa);
        num_rows   = (AW+1)'(n);
        @(posedge clk);
        #1;
        cs    = cyc;
        start = 1'b0;
    endtask

    task automatic run_drain(input int sa, input int n, input int mode, input bit timing, input bit intrude);
        int cs, d0, k, limit;
        rdy_mode = mode;
        push_expected(sa, n);
        beats   = 0;
        first_v = -1;
        d0      = done_cnt;
        issue_start(sa, n, cs);
        @(negedge clk);
        #1;
        chk("busy_after_start", busy, 1);
        k     = 0;
        limit = n * BANKS * 4 + 64;
        while (done_cnt == d0 && k < limit) begin
            if (intrude && k == 8) begin
                start      = 1'b1;
                start_addr = AW'(7);
                num_rows   = (AW+1)'(2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            #1;
            k++;
        end
        start = 1'b0;
        chk("done_count", done_cnt - d0, 1);
        chk("busy_at_done", busy, 0);
        chk("beat_count", beats, n * BANKS);
        chk("queue_empty", exp_q.size(), 0);
        if (timing) begin
            chk("first_tvalid_cyc", first_v, cs + 3);
            chk("gapless_span", last_hs - first_v, n * BANKS - 1);
            chk("done_after_last", done_cyc - last_hs, 1);
        end
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #3_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : stim
        logic [ROW_W-1:0] d;
        int cs, d0, b0, v0, k;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_addr = '0; num_rows = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_tdata", m_axis_tdata, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clk);
        #1;

        for (int r = 0; r < DEPTH; r++) begin
            for (int l = 0; l < BANKS; l++) d[l*WIDTH +: WIDTH] = $urandom;
            write_row(r, d);
        end
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < BANKS; l++) d[l*WIDTH +: WIDTH] = WIDTH'(r * 256 + l);
            write_row(r, d);
        end

        run_drain(0, 4, 1, 1'b1, 1'b0);
        run_drain(0, 4, 2, 1'b0, 1'b1);
        run_drain(510, 3, 2, 1'b0, 1'b0);

        d0 = done_cnt; b0 = busy_seen; v0 = vld_seen;
        issue_start(5, 0, cs);
        @(negedge clk);
        #1;
        chk("zero_done", done, 1);
        chk("zero_done_cyc", done_cyc, cs);
        repeat (5) @(negedge clk);
        #1;
        chk("zero_done_count", done_cnt - d0, 1);
        chk("zero_busy_seen", busy_seen - b0, 0);
        chk("zero_tvalid_seen", vld_seen - v0, 0);
        @(posedge clk);
        #1;

        run_drain(100, 512, 1, 1'b1, 1'b0);

        rdy_mode = 2;
        push_expected(0, 4);
        beats = 0;
        d0    = done_cnt;
        issue_start(0, 4, cs);
        k = 0;
        while (beats < 20 && k < 400) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("reached_20_beats", beats >= 20, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tlast", m_axis_tlast, 0);
        chk("midrst_tdata", m_axis_tdata, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_no_done", done_cnt - d0, 0);
        @(posedge clk);
        #1;
        run_drain(2, 3, 1, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int l = 0; l < BANKS; l++) d[l*WIDTH +: WIDTH] = $urandom;
            write_row(int'($urandom % DEPTH), d);
            run_drain(int'($urandom % DEPTH), 1 + int'($urandom % 6), (t % 2 == 0) ? 2 : 1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_c_drain.md
# mem_c_drain

Banked output buffer for the matrix-multiply datapath, mirroring the AXI-Stream-fed banked input buffers. The compute array writes one full row (BANKS lanes of WIDTH bits) per cycle into a UltraRAM-style memory. On a start command, a drain engine reads a contiguous run of rows and serialises each row lane-by-lane onto an AXI4-Stream master (MM2S direction) toward the DMA, with full back-pressure support and tlast on the final beat.

## Interface
Parameters:
- WIDTH, 32, bits per lane / per stream beat
- DEPTH, 512, rows in the memory
- BANKS, 16, lanes per row (beats per row)
- RD_LAT, 2, memory read latency in cycles (address registered to data registered)

Ports:
- clk  in  1  single clock for all logic
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  row write strobe from compute array
- wr_addr  in  $clog2(DEPTH)  row address for write
- wr_data  in  WIDTH*BANKS  row data; lane i at bits [(i+1)*WIDTH-1 : i*WIDTH]
- start  in  1  drain command pulse
- start_addr  in  $clog2(DEPTH)  first row to drain
- num_rows  in  $clog2(DEPTH)+1  rows to drain (0..DEPTH)
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse at drain completion
- m_axis_tdata  out  WIDTH  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  final beat of the drain

## Operation
- Memory: DEPTH x (WIDTH*BANKS), ram_style ultra, contents not reset. Write port always active (including during drain). Same-address same-cycle read/write returns old data (read-first); no other hazard protection.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: start with num_rows>0 latches start_addr/num_rows -> RUN, busy=1. start with num_rows==0 -> done pulse next cycle, no beats, stays IDLE. start ignored outside IDLE.
  - RUN: issues row reads; -> FLUSH when last row read issued.
  - FLUSH: waits for final handshake -> IDLE, done=1 for one cycle, busy=0 that same cycle.
- Read issue: one row read per cycle max, only when (free row-buffer entries − reads in flight) > 0. Row buffer: 2 entries (ping-pong). Read address increments by 1, wraps DEPTH-1 -> 0.
- Serialiser: emits lanes 0..BANKS-1 of the head row in order; entry frees after lane BANKS-1 handshakes.
- tlast=1 only on lane BANKS-1 of the last row.
- AXI rules: tvalid never depends on tready; once tvalid=1, tdata/tlast held stable until handshake (tvalid&&tready).
- Row counter width $clog2(DEPTH)+1; num_rows=DEPTH drains the whole memory exactly once (wrap-around from start_addr).

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, done=0; FSM IDLE; row buffer empty; in-flight count 0.
- Reset asserted mid-drain: all outputs drop to reset values immediately (asynchronously); pending reads discarded; no done.
- start sampled at edge T -> busy=1 from T+1; first read issued in cycle T+1; data in buffer at T+1+RD_LAT; first tvalid at T+2+RD_LAT.
- With tready held 1 and BANKS >= RD_LAT+2: gapless, one beat per cycle, total beats num_rows*BANKS in consecutive cycles. Smaller BANKS permits bubbles but ordering unchanged.
- done asserted cycle after final handshake.
- tready low for any duration: no beat lost or duplicated; reads stall when buffer full.

## Test plan
- Fill rows 0..3 with lane value {row,lane}; start_addr=0, num_rows=4, tready=1 -> 64 beats in order 0x0000..0x030F, gapless, tlast only on beat 64, first tvalid at T+4, done one cycle after last beat.
- Same drain with tready random 50% -> identical beat sequence, tdata/tlast stable while tvalid&&!tready, done after last handshake.
- start_addr=510, num_rows=3 (DEPTH=512) -> rows 510, 511, 0 emitted; 48 beats.
- num_rows=0 -> done pulse at T+1, busy never 1, tvalid never 1; start while busy -> ignored, beat count unchanged.
- num_rows=512 from start_addr=100 -> 8192 beats, every row exactly once, tlast only on final beat.
- rst_n low after 20 beats -> tvalid/busy fall immediately; new start after release drains correctly from scratch.
